// File: rtl/wb_master_seq.sv
// Wishbone classic single-transfer initiator.
// Takes one command at a time on a valid/ready port, runs one Wishbone cycle
// with a stb timeout, then holds the result on a valid/ready response port.
module wb_master_seq #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    // command port
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    input  logic [3:0]  cmd_sel,
    // response port
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    // Wishbone master
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i
);

    typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

    // Counter value seen in the last permitted stb cycle.
    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] rsp_dat_q, rsp_dat_d;
    logic        rsp_err_q, rsp_err_d;

    // State and datapath registers; reset drops cyc/stb asynchronously.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            rsp_dat_q <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            sel_q     <= sel_d;
            rsp_dat_q <= rsp_dat_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    // Next-state logic: accept, run the bus cycle, hold the response.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        sel_d     = sel_q;
        rsp_dat_d = rsp_dat_q;
        rsp_err_d = rsp_err_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    we_d    = cmd_we;
                    adr_d   = cmd_adr;
                    dat_d   = cmd_dat;
                    sel_d   = cmd_sel;
                    cnt_d   = '0;
                    state_d = StBus;
                end
            end
            StBus: begin
                cnt_d = cnt_q + 16'd1;
                // Ack wins over a timeout landing on the same cycle.
                if (wbm_ack_i) begin
                    rsp_dat_d = we_q ? 32'h0 : wbm_dat_i;
                    rsp_err_d = 1'b0;
                    state_d   = StResp;
                end else if (cnt_q == TimeoutLast) begin
                    rsp_dat_d = 32'h0;
                    rsp_err_d = 1'b1;
                    state_d   = StResp;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from the state register or taken straight from flops.
    always_comb begin
        cmd_ready = (state_q == StIdle);
        rsp_valid = (state_q == StResp);
        wbm_cyc_o = (state_q == StBus);
        wbm_stb_o = (state_q == StBus);
        wbm_we_o  = we_q;
        wbm_adr_o = adr_q;
        wbm_dat_o = dat_q;
        wbm_sel_o = sel_q;
        rsp_dat   = rsp_dat_q;
        rsp_err   = rsp_err_q;
    end

endmodule

// File: tb/tb_wb_master_seq.sv
// Self-checking bench for wb_master_seq with TIMEOUT=8.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_wb_master_seq;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
    logic [31:0] cmd_adr = '0, cmd_dat = '0;
    logic [3:0]  cmd_sel = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
    logic [31:0] rsp_dat;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_ack_i = 1'b0;
    logic [31:0] wbm_dat_i = '0;

    int n_checks = 0;
    int n_fail = 0;
    int cycles = 0;

    wb_master_seq #(.TIMEOUT(TO)) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_adr   (cmd_adr),
        .cmd_dat   (cmd_dat),
        .cmd_sel   (cmd_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_dat   (rsp_dat),
        .rsp_err   (rsp_err),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_ack_i (wbm_ack_i),
        .wbm_dat_i (wbm_dat_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycles <= cycles + 1;

    // Next command presented while a response is being back-pressured.
    logic        nxt_we;
    logic [31:0] nxt_adr, nxt_dat;
    logic [3:0]  nxt_sel;

    // One complete transfer. ack_wait < 0 means the responder never acks.
    // Must be entered at a falling edge with the block idle.
    task automatic run_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, input int ack_wait,
                            input logic [31:0] rdata, input int ready_delay,
                            input bit hold_cmd);
        int n, exp_n;
        bit exp_err;
        logic [31:0] exp_dat;
        exp_err = !(ack_wait >= 0 && ack_wait < int'(TO));
        exp_n   = exp_err ? int'(TO) : ack_wait + 1;
        exp_dat = (!exp_err && !we) ? rdata : 32'h0;

        n_checks++;
        if (cmd_ready !== 1'b1 || wbm_cyc_o !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_before_cmd: cmd_ready=%b cyc=%b, want 1 0", cmd_ready, wbm_cyc_o);
        end
        cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_we = $urandom; cmd_adr = $urandom; cmd_dat = $urandom;

        n = 0;
        while (wbm_stb_o === 1'b1 && n < 200) begin
            n_checks++;
            if ({wbm_cyc_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o, cmd_ready, rsp_valid}
                !== {1'b1, we, adr, dat, sel, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL bus_fields cyc%0d: cyc=%b we=%b adr=%h dat=%h sel=%h, want 1 %b %h %h %h",
                         n, wbm_cyc_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o, we, adr, dat, sel);
            end
            wbm_ack_i = (n == ack_wait);
            wbm_dat_i = (n == ack_wait) ? rdata : $urandom;
            rsp_ready = $urandom;
            @(negedge clk);
            n++;
        end
        wbm_ack_i = 1'b0;
        rsp_ready = 1'b0;

        n_checks++;
        if (n !== exp_n || rsp_valid !== 1'b1 || wbm_cyc_o !== 1'b0) begin
            n_fail++;
            $display("FAIL stb_length: stb_cycles=%0d rsp_valid=%b cyc=%b, want %0d 1 0",
                     n, rsp_valid, wbm_cyc_o, exp_n);
        end
        n_checks++;
        if (rsp_dat !== exp_dat || rsp_err !== exp_err) begin
            n_fail++;
            $display("FAIL rsp_value: dat=%h err=%b, want %h %b", rsp_dat, rsp_err, exp_dat, exp_err);
        end

        // Backpressure: response held, commands refused, stray acks ignored.
        for (int i = 0; i < ready_delay; i++) begin
            cmd_valid = hold_cmd;
            if (hold_cmd) begin
                cmd_we = nxt_we; cmd_adr = nxt_adr; cmd_dat = nxt_dat; cmd_sel = nxt_sel;
            end
            wbm_ack_i = (i == 1);
            wbm_dat_i = $urandom;
            @(negedge clk);
            n_checks++;
            if ({rsp_valid, rsp_dat, rsp_err, cmd_ready, wbm_cyc_o, wbm_stb_o}
                !== {1'b1, exp_dat, exp_err, 1'b0, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL rsp_hold%0d: valid=%b dat=%h err=%b ready=%b cyc=%b, want 1 %h %b 0 0",
                         i, rsp_valid, rsp_dat, rsp_err, cmd_ready, wbm_cyc_o, exp_dat, exp_err);
            end
        end
        wbm_ack_i = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        n_checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || wbm_cyc_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rsp_release: valid=%b cmd_ready=%b cyc=%b, want 0 1 0",
                     rsp_valid, cmd_ready, wbm_cyc_o);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_checks++;
        if ({cmd_ready, rsp_valid, rsp_err, rsp_dat, wbm_cyc_o, wbm_stb_o, wbm_we_o,
             wbm_adr_o, wbm_dat_o, wbm_sel_o} !== {1'b1, 1'b0, 1'b0, 32'h0, 3'b000,
             32'h0, 32'h0, 4'h0}) begin
            n_fail++;
            $display("FAIL reset_values: cmd_ready=%b rsp_valid=%b cyc=%b adr=%h dat=%h sel=%h, want 1 0 0 0 0 0",
                     cmd_ready, rsp_valid, wbm_cyc_o, wbm_adr_o, wbm_dat_o, wbm_sel_o);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1 || wbm_cyc_o !== 1'b0 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: cmd_ready=%b cyc=%b rsp_valid=%b, want 1 0 0",
                     cmd_ready, wbm_cyc_o, rsp_valid);
        end
    endtask

    task automatic test_write_ack_first();
        run_xfer(1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF, 0, 32'hDEAD_BEEF, 0, 1'b0);
    endtask

    task automatic test_read_wait();
        run_xfer(1'b0, 32'h3000_0010, 32'h1111_2222, 4'h3, 3, 32'hCAFE_F00D, 0, 1'b0);
    endtask

    task automatic test_timeout();
        // No ack at all, then an ack landing together with the timeout.
        run_xfer(1'b0, 32'h3000_0020, 32'h0, 4'hF, -1, 32'h1234_5678, 4, 1'b0);
        run_xfer(1'b0, 32'h3000_0024, 32'h0, 4'hF, int'(TO) - 1, 32'h8765_4321, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        int t0;
        nxt_we = 1'b1; nxt_adr = 32'h3000_0100; nxt_dat = 32'h0BAD_F00D; nxt_sel = 4'h5;
        run_xfer(1'b0, 32'h3000_0030, 32'h0, 4'hF, 1, 32'h5555_AAAA, 5, 1'b1);
        // Held command gets accepted one cycle after the response is taken.
        t0 = cycles;
        run_xfer(nxt_we, nxt_adr, nxt_dat, nxt_sel, 0, 32'h0, 0, 1'b0);
        n_checks++;
        if (cycles - t0 !== 3) begin
            n_fail++;
            $display("FAIL held_cmd_period: cycles=%0d, want 3", cycles - t0);
        end
    endtask

    task automatic test_back_to_back();
        int t0;
        t0 = cycles;
        for (int i = 0; i < 3; i++)
            run_xfer(1'(i), $urandom, $urandom, 4'(i + 1), 0, $urandom, 0, 1'b0);
        n_checks++;
        if (cycles - t0 !== 9) begin
            n_fail++;
            $display("FAIL back_to_back_period: cycles=%0d, want 9", cycles - t0);
        end
    endtask

    task automatic test_reset_mid_bus();
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0040; cmd_sel = 4'hF;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({wbm_cyc_o, wbm_stb_o, rsp_valid, cmd_ready, wbm_adr_o} !== {4'b0001, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_mid_bus: cyc=%b stb=%b rsp_valid=%b cmd_ready=%b adr=%h, want 0 0 0 1 0",
                     wbm_cyc_o, wbm_stb_o, rsp_valid, cmd_ready, wbm_adr_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_xfer(1'b0, 32'h3000_0044, 32'h0, 4'hC, 2, 32'h600D_600D, 1, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++)
            run_xfer(1'($urandom), $urandom, $urandom, 4'($urandom),
                     int'($urandom_range(0, 11)) - 1, $urandom,
                     int'($urandom_range(0, 3)), 1'b0);
    endtask

    initial begin
        test_reset();
        test_write_ack_first();
        test_read_wait();
        test_timeout();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_bus();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard stop in case a wait ever runs away.
    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete, want completion");
        $fatal(1);
    end

endmodule
